param_memory: RTL and testbench

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory.sv | 77 +++++++
 tb/tb_param_memory.sv | 138 +++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// Parameterised word memory with a sequential power-up clear, CPU port with
// priority over an image-loader port, and a debug window onto the array.
module param_memory #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 8,
  parameter logic [DATA_W-1:0] FILL   = '0,
  parameter bit              RD_REG   = 1'b0,
  parameter int              DBG_BASE = 0,
  parameter int              DBG_N    = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         in,
  output logic [DATA_W-1:0]         out,
  output logic                      busy,
  input  logic                      load_valid,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  output logic                      load_ready,
  output logic [DBG_N*DATA_W-1:0]   dbg_bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   counter;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      counter <= '0;
    end else if (state == CLEAR) begin
      counter <= counter + 1'b1;
      if (counter == {ADDR_W{1'b1}}) state <= RUN;
    end
  end

  // The array has no reset; a restarted clear leaves untouched words as they were.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[counter] <= FILL;
      else if (we)
        mem[addr] <= in;
      else if (load_valid)
        mem[load_addr] <= load_data;
    end
  end

  assign busy       = (state == CLEAR);
  assign load_ready = (state == RUN) && !we;

  generate
    if (RD_REG) begin : g_rd_reg
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) begin
        if (rst || state == CLEAR) out_q <= '0;
        else                       out_q <= mem[addr];
      end
      assign out = busy ? '0 : out_q;
    end else begin : g_rd_comb
      assign out = busy ? '0 : mem[addr];
    end
  endgenerate

  generate
    for (genvar k = 0; k < DBG_N; k++) begin : g_dbg
      assign dbg_bus[k*DATA_W +: DATA_W] = mem[DBG_BASE + k];
    end
  endgenerate

endmodule

// File: tb/tb_param_memory.sv
// Directed bench: three instances (default, registered read, FILL/debug-window
// variant) driven by a shared stimulus sequence.
module tb_param_memory;

  logic       clk = 1'b0;
  logic       rst, we, load_valid;
  logic [7:0] addr, in_d, load_addr, load_data;

  logic [7:0]   out0, out1, out2;
  logic         busy0, busy1, busy2;
  logic         lr0, lr1, lr2;
  logic [263:0] dbg0, dbg1;
  logic [79:0]  dbg2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_memory dut0 (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .in(in_d), .out(out0),
    .busy(busy0), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(lr0), .dbg_bus(dbg0));

  param_memory #(.RD_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .in(in_d), .out(out1),
    .busy(busy1), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(lr1), .dbg_bus(dbg1));

  param_memory #(.FILL(8'h3C), .DBG_BASE(215), .DBG_N(10)) dut2 (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .in(in_d), .out(out2),
    .busy(busy2), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(lr2), .dbg_bus(dbg2));

  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge where rst has just been released.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy0 === 1'b1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    #1;
    chk(tag, 272'(n), 272'd256);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; load_valid = 1'b0;
    addr = '0; in_d = '0; load_addr = '0; load_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy",  272'(busy0), 272'd1);
    chk("rst_lr",    272'(lr0),   272'd0);
    chk("rst_out1",  272'(out1),  272'd0);

    // first clear
    rst = 1'b0;
    wait_clear("clear_len");
    chk("run_busy1",   272'(busy1), 272'd0);
    chk("run_lr",      272'(lr0),   272'd1);
    chk("dbg0_zero",   272'(dbg0),  272'd0);
    chk("dbg2_fill",   272'(dbg2),  272'({10{8'h3C}}));

    // CPU write then read back
    we = 1'b1; addr = 8'd5; in_d = 8'hA7; #1;
    chk("rd_old",      272'(out0), 272'd0);
    @(negedge clk); we = 1'b0; #1;
    chk("rd_comb",     272'(out0), 272'hA7);
    chk("rd_reg_rbw",  272'(out1), 272'd0);
    chk("dbg_w5",      272'(dbg0[5*8 +: 8]), 272'hA7);
    @(negedge clk); #1;
    chk("rd_reg",      272'(out1), 272'hA7);

    // CPU vs loader collision
    load_valid = 1'b1; load_addr = 8'd33; load_data = 8'd67;
    we = 1'b1; addr = 8'd34; in_d = 8'd70; #1;
    chk("coll_lr",     272'(lr0), 272'd0);
    @(negedge clk); we = 1'b0; #1;
    chk("coll_cpu",    272'(out0), 272'd70);
    chk("coll_lr_hi",  272'(lr0), 272'd1);
    addr = 8'd33; #1;
    chk("coll_m33",    272'(out0), 272'd0);
    @(negedge clk); load_valid = 1'b0; #1;
    chk("load_m33",    272'(out0), 272'd67);

    // seed words that the restarted clear will revisit
    we = 1'b1; addr = 8'd200; in_d = 8'h55;
    @(negedge clk); addr = 8'd20; in_d = 8'h99;
    @(negedge clk); we = 1'b0; addr = 8'd200; #1;
    chk("seed_200",    272'(out0), 272'h55);
    chk("seed_20",     272'(dbg0[20*8 +: 8]), 272'h99);

    // restart clear; writes during clear must be ignored
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst2_busy",   272'(busy0), 272'd1);
    chk("rst2_out1",   272'(out1),  272'd0);
    rst = 1'b0;
    we = 1'b1; addr = 8'd20; in_d = 8'hFF;
    load_valid = 1'b1; load_addr = 8'd21; load_data = 8'h77;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("busy_lr",   272'(lr0),  272'd0);
      chk("busy_out0", 272'(out0), 272'd0);
      chk("busy_out1", 272'(out1), 272'd0);
      chk("busy_m20",  272'(dbg0[20*8 +: 8]), 272'h99);
      chk("busy_m21",  272'(dbg0[21*8 +: 8]), 272'h00);
      @(negedge clk);
    end
    we = 1'b0; load_valid = 1'b0; addr = 8'd200;
    repeat (85) @(negedge clk);
    #1;
    chk("mid_busy",    272'(busy0), 272'd1);
    chk("mid_m20",     272'(dbg0[20*8 +: 8]), 272'h00);

    // rst at counter 100
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_clear("reclear_len");
    chk("re_m200",     272'(out0), 272'h00);
    chk("re_m200_f",   272'(out2), 272'h3C);
    chk("re_dbg2",     272'(dbg2), 272'({10{8'h3C}}));
    @(negedge clk); #1;
    chk("re_m200_reg", 272'(out1), 272'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
